// File: rtl/chipid_model.sv
// Cycle-level stand-in for the FPGA chip ID block: timed serial fuse read ending in a held, valid ID.
// Optional macro CHIPID_AUTOREAD_EN: the first edge out of reset starts a read without readid.
module chipid_model #(
   parameter int unsigned     ID_W           = 64,
   parameter logic [ID_W-1:0] CHIP_ID        = 64'h0123456789ABCDEF,
   parameter int unsigned     FUSE_DELAY     = 16,
   parameter int unsigned     BITS_PER_CYCLE = 1
) (
   input  logic            clkin,
   input  logic            reset,
   input  logic            readid,
   output logic            data_valid,
   output logic [ID_W-1:0] chip_id,
   output logic            busy
);

   localparam int unsigned       N          = ID_W / BITS_PER_CYCLE;
   localparam int unsigned       CNT_W      = $clog2(N + 1);
   localparam logic [15:0]       WAIT_INIT  = (FUSE_DELAY > 0) ? 16'(FUSE_DELAY - 1) : 16'd0;
   localparam logic [CNT_W-1:0]  LAST_SLICE = CNT_W'(N - 1);

   generate
      if (ID_W % BITS_PER_CYCLE != 0) begin : g_err_div
         $error("chipid_model: BITS_PER_CYCLE must divide ID_W");
      end
      if (FUSE_DELAY > 65535) begin : g_err_delay
         $error("chipid_model: FUSE_DELAY must not exceed 65535");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [15:0]           wait_cnt_q, wait_cnt_d;
   logic [ID_W-1:0]       sr_q, sr_d;
   logic [CNT_W-1:0]      slice_cnt_q, slice_cnt_d;
   logic [ID_W-1:0]       chip_id_q, chip_id_d;
   logic                  data_valid_q, data_valid_d;
   logic                  busy_q, busy_d;

   logic                      go;
   logic [BITS_PER_CYCLE-1:0] slice;
   logic [ID_W-1:0]           sr_shift;
   int unsigned               shamt;

`ifdef CHIPID_AUTOREAD_EN
   logic auto_pend_q, auto_pend_d;

   // Set while in reset so the first released edge behaves like a sampled readid.
   always_ff @(posedge clkin) begin
      if (reset) auto_pend_q <= 1'b1;
      else       auto_pend_q <= auto_pend_d;
   end

   always_comb begin
      auto_pend_d = 1'b0;
      go          = readid | auto_pend_q;
   end
`else
   always_comb begin
      go = readid;
   end
`endif

   // Slices are taken MSB-first; out-of-range shifts past DONE simply yield zero.
   always_comb begin
      shamt    = (N - 1 - 32'(slice_cnt_q)) * BITS_PER_CYCLE;
      slice    = BITS_PER_CYCLE'(CHIP_ID >> shamt);
      sr_shift = (sr_q << BITS_PER_CYCLE) | ID_W'(slice);
   end

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      sr_d         = sr_q;
      slice_cnt_d  = slice_cnt_q;
      chip_id_d    = chip_id_q;
      data_valid_d = data_valid_q;
      busy_d       = busy_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (go) begin
               state_d      = (FUSE_DELAY > 0) ? ST_WAIT : ST_SHIFT;
               wait_cnt_d   = WAIT_INIT;
               sr_d         = '0;
               slice_cnt_d  = '0;
               busy_d       = 1'b1;
               data_valid_d = 1'b0;
               chip_id_d    = '0;
            end
         end
         ST_WAIT: begin
            if (wait_cnt_q == 16'd0) state_d    = ST_SHIFT;
            else                     wait_cnt_d = wait_cnt_q - 16'd1;
         end
         ST_SHIFT: begin
            sr_d        = sr_shift;
            slice_cnt_d = slice_cnt_q + CNT_W'(1);
            if (slice_cnt_q == LAST_SLICE) begin
               state_d      = ST_DONE;
               chip_id_d    = sr_shift;
               data_valid_d = 1'b1;
               busy_d       = 1'b0;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            busy_d       = 1'b0;
            data_valid_d = 1'b0;
            chip_id_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clkin) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         wait_cnt_q   <= '0;
         sr_q         <= '0;
         slice_cnt_q  <= '0;
         chip_id_q    <= '0;
         data_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         sr_q         <= sr_d;
         slice_cnt_q  <= slice_cnt_d;
         chip_id_q    <= chip_id_d;
         data_valid_q <= data_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign data_valid = data_valid_q;
   assign chip_id    = chip_id_q;
   assign busy       = busy_q;

endmodule
